noc_local_input_port: RTL and testbench

NOC_LOCAL_INPUT_PORT -- requirements
Module: noc_local_input_port

---
 rtl/noc_local_input_port.sv | 204 ++++++++++++++++++++
 tb/tb_noc_local_input_port.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_local_input_port.sv
// Local-node ingress port: flit FIFO, XY route computation and header/body packet FSM.
// Optional NOC_INPORT_FRAMING_CHECK_EN adds an ingress framing checker that drops malformed flits.
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif
`ifndef Noc_ID_X_Width
`define Noc_ID_X_Width 4
`endif
`ifndef Noc_ID_Y_Width
`define Noc_ID_Y_Width 4
`endif

module noc_local_input_port #(
    parameter logic [`Noc_ID_X_Width-1:0] X_ID  = '0,
    parameter logic [`Noc_ID_Y_Width-1:0] Y_ID  = '0,
    parameter int                         DEPTH = 4
) (
    input  logic                       noc_clk,
    input  logic                       noc_rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [`Noc_Data_Width-1:0] in_flit,
    input  logic                       in_is_header,
    input  logic                       in_is_tail,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [`Noc_Data_Width-1:0] out_flit,
    output logic                       out_is_header,
    output logic                       out_is_tail,
    output logic [2:0]                 out_dir,
    output logic [15:0]                pkt_count,
    output logic                       err_framing
);
    localparam int W  = `Noc_Data_Width;
    localparam int XW = `Noc_ID_X_Width;
    localparam int YW = `Noc_ID_Y_Width;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        DIR_LOCAL = 3'd0,
        DIR_EAST  = 3'd1,
        DIR_WEST  = 3'd2,
        DIR_NORTH = 3'd3,
        DIR_SOUTH = 3'd4
    } dir_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BODY = 1'b1
    } state_t;

    // Each entry holds {header, tail, payload}
    logic [W+1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [15:0]   r_pkt_count;
    state_t        r_state;
    state_t        w_state_next;
    dir_t          r_dir;
    dir_t          w_dir_next;
    dir_t          w_dir;
    dir_t          w_route;

    logic          w_full;
    logic          w_empty;
    logic          w_accept;
    logic          w_store;
    logic          w_push;
    logic          w_pop;
    logic [W+1:0]  w_head;
    logic          w_head_hdr;
    logic          w_head_tail;
    logic [XW-1:0] w_dest_x;
    logic [YW-1:0] w_dest_y;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    // Held low while reset is asserted so nothing is offered into a FIFO being cleared
    assign in_ready  = noc_rst_n && !w_full;
    assign w_accept  = in_valid && in_ready;
    assign w_push    = w_accept && w_store;
    assign out_valid = !w_empty;
    assign w_pop     = out_valid && out_ready;

    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_hdr  = w_head[W+1];
    assign w_head_tail = w_head[W];
    assign w_dest_x    = w_head[W-1 -: XW];
    assign w_dest_y    = w_head[W-1-XW -: YW];

    assign out_flit      = w_head[W-1:0];
    assign out_is_header = w_head_hdr;
    assign out_is_tail   = w_head_tail;
    assign out_dir       = w_dir;
    assign pkt_count     = r_pkt_count;

    always_ff @(posedge noc_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_is_header, in_is_tail, in_flit};
        end
    end

    always_ff @(posedge noc_clk) begin
        if (!noc_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Dimension-ordered routing: resolve X first, then Y
    always_comb begin
        w_route = DIR_LOCAL;
        if (w_dest_x > X_ID) begin
            w_route = DIR_EAST;
        end else if (w_dest_x < X_ID) begin
            w_route = DIR_WEST;
        end else if (w_dest_y > Y_ID) begin
            w_route = DIR_NORTH;
        end else if (w_dest_y < Y_ID) begin
            w_route = DIR_SOUTH;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_dir_next   = r_dir;
        w_dir        = r_dir;
        case (r_state)
            S_IDLE: begin
                if (!w_empty && w_head_hdr) begin
                    w_dir = w_route;
                    if (w_pop) begin
                        w_dir_next = w_route;
                        if (!w_head_tail) begin
                            w_state_next = S_BODY;
                        end
                    end
                end
            end
            S_BODY: begin
                if (w_pop && w_head_tail) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge noc_clk) begin
        if (!noc_rst_n) begin
            r_state     <= S_IDLE;
            r_dir       <= DIR_LOCAL;
            r_pkt_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_dir   <= w_dir_next;
            if (w_pop && w_head_tail) begin
                r_pkt_count <= r_pkt_count + 16'd1;
            end
        end
    end

`ifdef NOC_INPORT_FRAMING_CHECK_EN
    logic r_in_pkt;
    logic r_err;
    logic w_bad;

    // A header is legal only between packets; body/tail only inside one
    assign w_bad       = in_is_header ? r_in_pkt : !r_in_pkt;
    assign w_store     = !w_bad;
    assign err_framing = r_err;

    always_ff @(posedge noc_clk) begin
        if (!noc_rst_n) begin
            r_in_pkt <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_err <= w_accept && w_bad;
            if (w_accept && !w_bad) begin
                r_in_pkt <= !in_is_tail;
            end
        end
    end
`else
    assign w_store     = 1'b1;
    assign err_framing = 1'b0;
`endif

endmodule

// File: tb/tb_noc_local_input_port.sv
// Directed testbench for noc_local_input_port (X_ID=2, Y_ID=2, DEPTH=4).
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif
`ifndef Noc_ID_X_Width
`define Noc_ID_X_Width 4
`endif
`ifndef Noc_ID_Y_Width
`define Noc_ID_Y_Width 4
`endif

module tb_noc_local_input_port;
    localparam int W  = `Noc_Data_Width;
    localparam int XW = `Noc_ID_X_Width;
    localparam int YW = `Noc_ID_Y_Width;

    logic          noc_clk = 1'b0;
    logic          noc_rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_flit = '0;
    logic          in_is_header = 1'b0;
    logic          in_is_tail = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_flit;
    logic          out_is_header;
    logic          out_is_tail;
    logic [2:0]    out_dir;
    logic [15:0]   pkt_count;
    logic          err_framing;

    noc_local_input_port #(
        .X_ID (XW'(2)),
        .Y_ID (YW'(2)),
        .DEPTH(4)
    ) dut (
        .noc_clk      (noc_clk),
        .noc_rst_n    (noc_rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_flit      (in_flit),
        .in_is_header (in_is_header),
        .in_is_tail   (in_is_tail),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_flit     (out_flit),
        .out_is_header(out_is_header),
        .out_is_tail  (out_is_tail),
        .out_dir      (out_dir),
        .pkt_count    (pkt_count),
        .err_framing  (err_framing)
    );

    always #5 noc_clk = ~noc_clk;

    int           errors = 0;
    int           checks = 0;
    logic [W-1:0] tx_flit[$];
    logic         tx_hdr[$];
    logic         tx_tail[$];
    logic [W-1:0] got_flit[$];
    logic [2:0]   got_dir[$];
    int           err_pulses;
    int           stab_errs;
    int           hold_acc;
    logic         hold_ready;

    function automatic logic [W-1:0] hdrf(input int dx, input int dy, input logic [7:0] tag);
        logic [W-1:0] f;
        f = '0;
        f[W-1 -: XW]    = XW'(dx);
        f[W-1-XW -: YW] = YW'(dy);
        f[7:0]          = tag;
        return f;
    endfunction

    task automatic q(input logic [W-1:0] f, input logic h, input logic t);
        tx_flit.push_back(f);
        tx_hdr.push_back(h);
        tx_tail.push_back(t);
    endtask

    // Streams the tx queue into the DUT, collecting every output handshake.
    // mode 0: out_ready high; mode 1: out_ready toggles. out_ready is low for the first 'hold' cycles.
    task automatic drive(input int mode, input int hold);
        int           cyc;
        logic         acc;
        logic         pv_stall;
        logic [W-1:0] pv_flit;
        logic [2:0]   pv_dir;
        got_flit.delete();
        got_dir.delete();
        err_pulses = 0;
        stab_errs  = 0;
        hold_acc   = 0;
        hold_ready = 1'b1;
        pv_stall   = 1'b0;
        pv_flit    = '0;
        pv_dir     = '0;
        cyc        = 0;
        forever begin
            if (tx_flit.size() > 0) begin
                in_valid     = 1'b1;
                in_flit      = tx_flit[0];
                in_is_header = tx_hdr[0];
                in_is_tail   = tx_tail[0];
            end else begin
                in_valid     = 1'b0;
                in_flit      = '0;
                in_is_header = 1'b0;
                in_is_tail   = 1'b0;
            end
            if (cyc < hold) out_ready = 1'b0;
            else if (mode == 1) out_ready = (cyc % 2 == 1);
            else out_ready = 1'b1;
            #1;
            if (tx_flit.size() == 0 && !out_valid && !err_framing) break;
            if (cyc >= 200) begin
                errors++;
                checks++;
                $display("FAIL drive_timeout: cycles=%0d pending_tx=%0d required drain", cyc, tx_flit.size());
                break;
            end
            if (err_framing) err_pulses++;
            if (pv_stall && (out_flit !== pv_flit || out_dir !== pv_dir)) stab_errs++;
            pv_stall = out_valid && !out_ready;
            pv_flit  = out_flit;
            pv_dir   = out_dir;
            acc = in_valid && in_ready;
            if (cyc < hold && acc) hold_acc++;
            if (cyc == hold - 1) hold_ready = in_ready;
            if (out_valid && out_ready) begin
                got_flit.push_back(out_flit);
                got_dir.push_back(out_dir);
            end
            @(posedge noc_clk);
            @(negedge noc_clk);
            if (acc) begin
                void'(tx_flit.pop_front());
                void'(tx_hdr.pop_front());
                void'(tx_tail.pop_front());
            end
            cyc++;
        end
        in_valid     = 1'b0;
        in_is_header = 1'b0;
        in_is_tail   = 1'b0;
        out_ready    = 1'b0;
    endtask

    task automatic test_reset();
        noc_rst_n = 1'b0;
        @(negedge noc_clk);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (pkt_count !== 16'd0) begin errors++; $display("FAIL reset_pkt_count: got %0d expected 0", pkt_count); end
        checks++; if (err_framing !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err_framing); end
        checks++; if (out_dir !== 3'd0) begin errors++; $display("FAIL reset_out_dir: got %0d expected 0", out_dir); end
        noc_rst_n = 1'b1;
        @(posedge noc_clk);
        @(negedge noc_clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_out_valid: got %b expected 0", out_valid); end
        $display("test_reset done");
    endtask

    task automatic test_multi_flit();
        logic [W-1:0] exp_f[4];
        exp_f[0] = hdrf(3, 1, 8'hA1);
        exp_f[1] = 32'h1111_1111;
        exp_f[2] = 32'h2222_2222;
        exp_f[3] = 32'h3333_3333;
        q(exp_f[0], 1'b1, 1'b0);
        q(exp_f[1], 1'b0, 1'b0);
        q(exp_f[2], 1'b0, 1'b0);
        q(exp_f[3], 1'b0, 1'b1);
        drive(0, 0);
        checks++; if (got_flit.size() !== 4) begin errors++; $display("FAIL multi_count: got %0d expected 4", got_flit.size()); end
        for (int i = 0; i < 4 && i < got_flit.size(); i++) begin
            checks++; if (got_flit[i] !== exp_f[i]) begin errors++; $display("FAIL multi_flit%0d: got %h expected %h", i, got_flit[i], exp_f[i]); end
            checks++; if (got_dir[i] !== 3'd1) begin errors++; $display("FAIL multi_dir%0d: got %0d expected 1", i, got_dir[i]); end
        end
        checks++; if (pkt_count !== 16'd1) begin errors++; $display("FAIL multi_pkt_count: got %0d expected 1", pkt_count); end
        $display("test_multi_flit: delivered %0d flits, pkt_count=%0d", got_flit.size(), pkt_count);
    endtask

    task automatic test_single_flit();
        // Second single-flit packet routes WEST; a stuck BODY state would hold LOCAL instead
        q(hdrf(2, 2, 8'hB1), 1'b1, 1'b1);
        q(hdrf(1, 2, 8'hB2), 1'b1, 1'b1);
        drive(0, 0);
        checks++; if (got_flit.size() !== 2) begin errors++; $display("FAIL single_count: got %0d expected 2", got_flit.size()); end
        if (got_flit.size() == 2) begin
            checks++; if (got_dir[0] !== 3'd0) begin errors++; $display("FAIL single_dir_local: got %0d expected 0", got_dir[0]); end
            checks++; if (got_dir[1] !== 3'd2) begin errors++; $display("FAIL single_dir_west: got %0d expected 2", got_dir[1]); end
            checks++; if (got_flit[1] !== hdrf(1, 2, 8'hB2)) begin errors++; $display("FAIL single_flit1: got %h expected %h", got_flit[1], hdrf(1, 2, 8'hB2)); end
        end
        checks++; if (pkt_count !== 16'd3) begin errors++; $display("FAIL single_pkt_count: got %0d expected 3", pkt_count); end
        $display("test_single_flit: delivered %0d flits, pkt_count=%0d", got_flit.size(), pkt_count);
    endtask

    task automatic test_backpressure();
        logic [W-1:0] exp_f[6];
        exp_f[0] = hdrf(2, 3, 8'hC0);
        for (int i = 1; i < 6; i++) exp_f[i] = 32'hC000_0000 + i;
        q(exp_f[0], 1'b1, 1'b0);
        for (int i = 1; i < 5; i++) q(exp_f[i], 1'b0, 1'b0);
        q(exp_f[5], 1'b0, 1'b1);
        drive(0, 8);
        checks++; if (hold_acc !== 4) begin errors++; $display("FAIL bp_accepted_while_stalled: got %0d expected 4", hold_acc); end
        checks++; if (hold_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_full: got %b expected 0", hold_ready); end
        checks++; if (got_flit.size() !== 6) begin errors++; $display("FAIL bp_count: got %0d expected 6", got_flit.size()); end
        for (int i = 0; i < 6 && i < got_flit.size(); i++) begin
            checks++; if (got_flit[i] !== exp_f[i]) begin errors++; $display("FAIL bp_flit%0d: got %h expected %h", i, got_flit[i], exp_f[i]); end
            checks++; if (got_dir[i] !== 3'd3) begin errors++; $display("FAIL bp_dir%0d: got %0d expected 3", i, got_dir[i]); end
        end
        checks++; if (pkt_count !== 16'd4) begin errors++; $display("FAIL bp_pkt_count: got %0d expected 4", pkt_count); end
        $display("test_backpressure: accepted %0d while stalled, delivered %0d", hold_acc, got_flit.size());
    endtask

    task automatic test_toggle();
        logic [W-1:0] exp_f[5];
        exp_f[0] = hdrf(2, 0, 8'hD0);
        for (int i = 1; i < 5; i++) exp_f[i] = 32'hD000_0000 + i;
        q(exp_f[0], 1'b1, 1'b0);
        for (int i = 1; i < 4; i++) q(exp_f[i], 1'b0, 1'b0);
        q(exp_f[4], 1'b0, 1'b1);
        drive(1, 0);
        checks++; if (got_flit.size() !== 5) begin errors++; $display("FAIL toggle_count: got %0d expected 5", got_flit.size()); end
        for (int i = 0; i < 5 && i < got_flit.size(); i++) begin
            checks++; if (got_flit[i] !== exp_f[i]) begin errors++; $display("FAIL toggle_flit%0d: got %h expected %h", i, got_flit[i], exp_f[i]); end
            checks++; if (got_dir[i] !== 3'd4) begin errors++; $display("FAIL toggle_dir%0d: got %0d expected 4", i, got_dir[i]); end
        end
        checks++; if (stab_errs !== 0) begin errors++; $display("FAIL toggle_stall_stability: got %0d changes expected 0", stab_errs); end
        checks++; if (pkt_count !== 16'd5) begin errors++; $display("FAIL toggle_pkt_count: got %0d expected 5", pkt_count); end
        $display("test_toggle: delivered %0d flits", got_flit.size());
    endtask

    task automatic test_framing();
        logic [W-1:0] stray;
        logic [W-1:0] h1;
        stray = 32'hDEAD_0001;
        h1    = hdrf(3, 2, 8'hE1);
        // Part A: body flit with no open packet, then a single-flit packet
        q(stray, 1'b0, 1'b0);
        q(h1, 1'b1, 1'b1);
        drive(0, 0);
`ifdef NOC_INPORT_FRAMING_CHECK_EN
        checks++; if (got_flit.size() !== 1) begin errors++; $display("FAIL frame_stray_count: got %0d expected 1", got_flit.size()); end
        checks++; if (err_pulses !== 1) begin errors++; $display("FAIL frame_stray_err: got %0d pulses expected 1", err_pulses); end
        if (got_flit.size() == 1) begin
            checks++; if (got_flit[0] !== h1) begin errors++; $display("FAIL frame_stray_next: got %h expected %h", got_flit[0], h1); end
            checks++; if (got_dir[0] !== 3'd1) begin errors++; $display("FAIL frame_stray_dir: got %0d expected 1", got_dir[0]); end
        end
`else
        checks++; if (got_flit.size() !== 2) begin errors++; $display("FAIL frame_stray_count: got %0d expected 2", got_flit.size()); end
        checks++; if (err_pulses !== 0) begin errors++; $display("FAIL frame_stray_err: got %0d pulses expected 0", err_pulses); end
        if (got_flit.size() == 2) begin
            checks++; if (got_flit[0] !== stray) begin errors++; $display("FAIL frame_stray_fwd: got %h expected %h", got_flit[0], stray); end
            checks++; if (got_dir[1] !== 3'd1) begin errors++; $display("FAIL frame_stray_dir: got %0d expected 1", got_dir[1]); end
        end
`endif
        checks++; if (pkt_count !== 16'd6) begin errors++; $display("FAIL frame_a_pkt_count: got %0d expected 6", pkt_count); end
        // Part B: a second header inside an open packet
        q(h1, 1'b1, 1'b0);
        q(hdrf(0, 0, 8'hE2), 1'b1, 1'b0);
        q(32'hE000_0003, 1'b0, 1'b1);
        drive(0, 0);
`ifdef NOC_INPORT_FRAMING_CHECK_EN
        checks++; if (got_flit.size() !== 2) begin errors++; $display("FAIL frame_dup_count: got %0d expected 2", got_flit.size()); end
        checks++; if (err_pulses !== 1) begin errors++; $display("FAIL frame_dup_err: got %0d pulses expected 1", err_pulses); end
`else
        checks++; if (got_flit.size() !== 3) begin errors++; $display("FAIL frame_dup_count: got %0d expected 3", got_flit.size()); end
        checks++; if (err_pulses !== 0) begin errors++; $display("FAIL frame_dup_err: got %0d pulses expected 0", err_pulses); end
`endif
        if (got_flit.size() > 0) begin
            checks++; if (got_dir[got_dir.size()-1] !== 3'd1) begin errors++; $display("FAIL frame_dup_tail_dir: got %0d expected 1", got_dir[got_dir.size()-1]); end
        end
        checks++; if (pkt_count !== 16'd7) begin errors++; $display("FAIL frame_b_pkt_count: got %0d expected 7", pkt_count); end
        $display("test_framing: part B delivered %0d flits, err pulses %0d", got_flit.size(), err_pulses);
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] exp_f[3];
        in_valid     = 1'b1;
        in_flit      = hdrf(1, 2, 8'hF0);
        in_is_header = 1'b1;
        in_is_tail   = 1'b0;
        out_ready    = 1'b0;
        @(posedge noc_clk);
        @(negedge noc_clk);
        in_flit      = 32'hF000_0001;
        in_is_header = 1'b0;
        out_ready    = 1'b1;
        @(posedge noc_clk);
        @(negedge noc_clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %b expected 1", out_valid); end
        checks++; if (out_dir !== 3'd2) begin errors++; $display("FAIL mid_pre_dir: got %0d expected 2", out_dir); end
        noc_rst_n = 1'b0;
        @(posedge noc_clk);
        @(negedge noc_clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b expected 0", out_valid); end
        checks++; if (pkt_count !== 16'd0) begin errors++; $display("FAIL mid_rst_pkt_count: got %0d expected 0", pkt_count); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_in_ready: got %b expected 0", in_ready); end
        checks++; if (out_dir !== 3'd0) begin errors++; $display("FAIL mid_rst_dir: got %0d expected 0", out_dir); end
        noc_rst_n = 1'b1;
        @(posedge noc_clk);
        @(negedge noc_clk);
        exp_f[0] = hdrf(3, 2, 8'hF8);
        exp_f[1] = 32'hF800_0001;
        exp_f[2] = 32'hF800_0002;
        q(exp_f[0], 1'b1, 1'b0);
        q(exp_f[1], 1'b0, 1'b0);
        q(exp_f[2], 1'b0, 1'b1);
        drive(0, 0);
        checks++; if (got_flit.size() !== 3) begin errors++; $display("FAIL mid_new_count: got %0d expected 3", got_flit.size()); end
        for (int i = 0; i < 3 && i < got_flit.size(); i++) begin
            checks++; if (got_flit[i] !== exp_f[i]) begin errors++; $display("FAIL mid_new_flit%0d: got %h expected %h", i, got_flit[i], exp_f[i]); end
            checks++; if (got_dir[i] !== 3'd1) begin errors++; $display("FAIL mid_new_dir%0d: got %0d expected 1", i, got_dir[i]); end
        end
        checks++; if (pkt_count !== 16'd1) begin errors++; $display("FAIL mid_new_pkt_count: got %0d expected 1", pkt_count); end
        $display("test_reset_mid: delivered %0d flits after reset", got_flit.size());
    endtask

    initial begin
        test_reset();
        test_multi_flit();
        test_single_flit();
        test_backpressure();
        test_toggle();
        test_framing();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
